// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 PIC interrupt-acknowledge path.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACK1      = 3'd1,
        ST_GAP       = 3'd2,
        ST_ACK2      = 3'd3,
        ST_DELIVER   = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_EOI       = 3'd6
    } inta_state_t;

    localparam logic [7:0] OCW2_NONSPEC_EOI = 8'h20;

    localparam int INTA_LOW_DEFAULT = 2;
    localparam int INTA_GAP_DEFAULT = 1;

endpackage

// File: rtl/inta_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous PIC INT level.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side 8259 INTA sequencer: two INTA pulses, vector capture,
// valid/ready delivery to the core and optional OCW2 EOI write.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = INTA_LOW_DEFAULT,
    parameter int INTA_GAP_CYCLES = INTA_GAP_DEFAULT,
    parameter bit AUTO_EOI        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    input  logic       handler_done,
    output logic       ocw2_wr,
    output logic [7:0] ocw2_data,
    output logic       spurious,
    output logic       busy
);

    localparam int CNT_MAX = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                             INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES - 1);

    inta_state_t   state;
    inta_state_t   nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          int_sync;
    logic          capture;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (int_req),
        .q     (int_sync)
    );

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            ST_IDLE: begin
                if (int_sync && int_enable) begin
                    nxt     = ST_ACK1;
                    cnt_nxt = LOW_LOAD;
                end
            end
            ST_ACK1: begin
                if (cnt == '0) begin
                    nxt     = ST_GAP;
                    cnt_nxt = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    nxt     = ST_ACK2;
                    cnt_nxt = LOW_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_ACK2: begin
                if (cnt == '0) nxt = ST_DELIVER;
                else           cnt_nxt = cnt - CW'(1);
            end
            ST_DELIVER: begin
                if (vector_ready) nxt = AUTO_EOI ? ST_IDLE : ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (handler_done) nxt = ST_EOI;
            end
            ST_EOI:  nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    assign capture = (state == ST_ACK2) && (nxt == ST_DELIVER);

    // inta_n follows the next state so the pin itself is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            inta_n   <= 1'b1;
            vector   <= 8'h00;
            spurious <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            inta_n <= !((nxt == ST_ACK1) || (nxt == ST_ACK2));
            if (capture) begin
                vector   <= data_in;
                spurious <= !int_sync && (data_in[2:0] == 3'd7);
            end
        end
    end

    assign vector_valid = (state == ST_DELIVER);
    assign ocw2_wr      = (state == ST_EOI);
    assign ocw2_data    = ocw2_wr ? OCW2_NONSPEC_EOI : 8'h00;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: EOI and auto-EOI instances on shared stimulus.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_req;
    logic       int_enable;
    logic [7:0] data_in;
    logic       vector_ready;
    logic       handler_done;

    logic       inta_n_m, vv_m, ocw2_wr_m, spurious_m, busy_m;
    logic [7:0] vector_m, ocw2_data_m;
    logic       inta_n_a, vv_a, ocw2_wr_a, spurious_a, busy_a;
    logic [7:0] vector_a, ocw2_data_a;

    int checks = 0;
    int errors = 0;
    int eoi_m = 0;
    int eoi_a = 0;
    int exp_eoi = 0;
    logic [8:0] q_m[$];
    logic [8:0] q_a[$];

    always #5 clk = ~clk;

    inta_sequencer #(
        .INTA_LOW_CYCLES (2),
        .INTA_GAP_CYCLES (1),
        .AUTO_EOI        (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_req      (int_req),
        .int_enable   (int_enable),
        .data_in      (data_in),
        .inta_n       (inta_n_m),
        .vector       (vector_m),
        .vector_valid (vv_m),
        .vector_ready (vector_ready),
        .handler_done (handler_done),
        .ocw2_wr      (ocw2_wr_m),
        .ocw2_data    (ocw2_data_m),
        .spurious     (spurious_m),
        .busy         (busy_m)
    );

    inta_sequencer #(
        .INTA_LOW_CYCLES (2),
        .INTA_GAP_CYCLES (1),
        .AUTO_EOI        (1'b1)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_req      (int_req),
        .int_enable   (int_enable),
        .data_in      (data_in),
        .inta_n       (inta_n_a),
        .vector       (vector_a),
        .vector_valid (vv_a),
        .vector_ready (vector_ready),
        .handler_done (handler_done),
        .ocw2_wr      (ocw2_wr_a),
        .ocw2_data    (ocw2_data_a),
        .spurious     (spurious_a),
        .busy         (busy_a)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset view of both instances: inta_n, valid, wr, data, spurious, busy, vector
    task automatic chk_reset(input string nm);
        chk({nm, "_m"}, 32'({inta_n_m, vv_m, ocw2_wr_m, ocw2_data_m,
                             spurious_m, busy_m, vector_m}),
            32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}));
        chk({nm, "_a"}, 32'({inta_n_a, vv_a, ocw2_wr_a, ocw2_data_a,
                             spurious_a, busy_a, vector_a}),
            32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}));
    endtask

    // Edges counted from int_req rising (first=1) or int_enable rising
    // with int_sync already high (first=3). INTA low after edges 3,4,6,7.
    task automatic run_seq(input logic [7:0] d, input bit drop,
                           input int rdy_dly, input int done_dly,
                           input bit done_on_hs, input int first);
        bit sp;
        bit low;
        sp = drop && (d[2:0] == 3'd7);
        q_m.push_back({sp, d});
        q_a.push_back({sp, d});
        if (first == 1) int_req = 1'b1;
        else            int_enable = 1'b1;
        data_in = 8'($urandom);
        for (int e = first; e <= 8; e++) begin
            tick();
            low = (e == 3) || (e == 4) || (e == 6) || (e == 7);
            chk($sformatf("inta_n_e%0d", e), 32'({inta_n_m, inta_n_a}),
                low ? 32'd0 : 32'd3);
            if (e == 5 && drop) int_req = 1'b0;
            if (e == 6) data_in = d;
        end
        chk("valid_at_capture", 32'({vv_m, vv_a}), 32'd3);
        chk("vector_m", 32'(vector_m), 32'(d));
        chk("vector_a", 32'(vector_a), 32'(d));
        chk("spurious", 32'({spurious_m, spurious_a}), sp ? 32'd3 : 32'd0);
        int_req = 1'b0;
        data_in = 8'($urandom);
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            chk("valid_hold", 32'({vv_m, vv_a}), 32'd3);
        end
        vector_ready = 1'b1;
        handler_done = done_on_hs;
        tick();
        vector_ready = 1'b0;
        handler_done = 1'b0;
        chk("valid_drop", 32'({vv_m, vv_a}), 32'd0);
        chk("busy_after_hs", 32'({busy_m, busy_a, ocw2_wr_m}), 32'b100);
        for (int i = 0; i < done_dly; i++) begin
            tick();
            chk("wait_done", 32'({busy_m, ocw2_wr_m, busy_a}), 32'b100);
        end
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        chk("eoi", 32'({ocw2_wr_m, ocw2_data_m}), 32'({1'b1, 8'h20}));
        exp_eoi++;
        tick();
        chk("idle_after_eoi", 32'({busy_m, ocw2_wr_m, ocw2_data_m}), 32'd0);
        tick();
    endtask

    initial begin : mon
        logic [8:0] e9;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (vv_m && vector_ready) begin
                    if (q_m.size() == 0) chk("sb_empty_m", 32'd1, 32'd0);
                    else begin
                        e9 = q_m.pop_front();
                        chk("sb_vec_m", 32'({spurious_m, vector_m}), 32'(e9));
                    end
                end
                if (vv_a && vector_ready) begin
                    if (q_a.size() == 0) chk("sb_empty_a", 32'd1, 32'd0);
                    else begin
                        e9 = q_a.pop_front();
                        chk("sb_vec_a", 32'({spurious_a, vector_a}), 32'(e9));
                    end
                end
                if (ocw2_wr_m) begin
                    eoi_m++;
                    chk("ocw2_data", 32'(ocw2_data_m), 32'h20);
                end
                if (ocw2_wr_a) eoi_a++;
            end
        end
    end

    initial begin : stim
        logic [7:0] d;
        rst_n        = 1'b0;
        int_req      = 1'b0;
        int_enable   = 1'b1;
        data_in      = 8'h00;
        vector_ready = 1'b0;
        handler_done = 1'b0;
        repeat (2) tick();
        chk_reset("reset_init");
        rst_n = 1'b1;

        run_seq(8'h43, 1'b0, 5, 3, 1'b0, 1);
        run_seq(8'h47, 1'b1, 2, 1, 1'b1, 1);

        int_enable = 1'b0;
        int_req    = 1'b1;
        repeat (6) begin
            tick();
            chk("enable_gate", 32'({inta_n_m, inta_n_a, busy_m, busy_a}),
                32'b1100);
        end
        run_seq(8'hA5, 1'b0, 3, 2, 1'b0, 3);

        // Abort mid-ACK2 with an asynchronous reset
        int_req = 1'b1;
        repeat (6) tick();
        chk("pre_reset_inta", 32'({inta_n_m, inta_n_a}), 32'd0);
        #1 rst_n = 1'b0;
        #1 chk_reset("reset_mid_ack2");
        #1 rst_n = 1'b1;
        run_seq(8'h9F, 1'b0, 4, 0, 1'b1, 1);

        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) d[2:0] = 3'd7;
            run_seq(d, 1'($urandom_range(0, 1)), $urandom_range(2, 8),
                    $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1);
        end

        repeat (3) tick();
        chk("eoi_count_m", 32'(eoi_m), 32'(exp_eoi));
        chk("eoi_count_a", 32'(eoi_a), 32'd0);
        chk("sb_drained", 32'(q_m.size() + q_a.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

CPU-side interrupt-acknowledge initiator for the 8259 PIC. Watches the PIC `INT` line, drives the two-pulse `INTA_n` sequence, captures the vector byte the PIC places on the data bus during the second pulse, and hands it to the CPU core over a valid/ready handshake. When the handler finishes, it issues the non-specific EOI (OCW2) write back to the PIC, unless the PIC is configured for auto-EOI. It sits between the PIC's priority resolver and the CPU core model.

## Interface
- `INTA_LOW_CYCLES`, 2: clocks each INTA pulse is held low; must be ≥1.
- `INTA_GAP_CYCLES`, 1: clocks `inta_n` is high between the two pulses; must be ≥1.
- `AUTO_EOI`, 0: 1 = PIC is in auto-EOI mode, so no OCW2 write is issued.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `int_req` in 1: PIC `INT`; asynchronous level.
- `int_enable` in 1: CPU interrupt-enable flag; sampled only in IDLE.
- `data_in` in 8: PIC data bus.
- `inta_n` out 1: interrupt acknowledge to PIC, active low, registered.
- `vector` out 8: captured vector `{T7..T3, IR index}`.
- `vector_valid` out 1: vector available.
- `vector_ready` in 1: core accepts the vector.
- `handler_done` in 1: single-cycle pulse, handler complete.
- `ocw2_wr` out 1: single-cycle OCW2 write strobe.
- `ocw2_data` out 8: 8'h20 (non-specific EOI) while `ocw2_wr` is high, else 8'h00.
- `spurious` out 1: the captured vector has index 7 and `int_req` was low at capture. Valid with `vector_valid`.
- `busy` out 1: state ≠ IDLE.

## Operation
- `int_req` passes through a 2-flop synchronizer to give `int_sync`. All other inputs are synchronous.
- States:
  - IDLE → ACK1 when `int_sync && int_enable`.
  - ACK1 (`inta_n`=0, `INTA_LOW_CYCLES` clocks) → GAP.
  - GAP (`inta_n`=1, `INTA_GAP_CYCLES` clocks) → ACK2.
  - ACK2 (`inta_n`=0, `INTA_LOW_CYCLES` clocks) → DELIVER. `data_in` is captured into `vector` on the edge that ends ACK2. `spurious` is set from `!int_sync && data_in[2:0]==7` on that same edge.
  - DELIVER (`vector_valid`=1): on `vector_ready` → IDLE if `AUTO_EOI`, else WAIT_DONE.
  - WAIT_DONE: on `handler_done` → EOI.
  - EOI (`ocw2_wr`=1, `ocw2_data`=8'h20, one clock) → IDLE.
- A single down-counter times ACK1, GAP and ACK2. Its width is `$clog2(max(INTA_LOW_CYCLES,INTA_GAP_CYCLES)+1)`. It loads N-1 on state entry, and the state advances when it reaches 0.
- `int_req` falling during ACK1, GAP or ACK2 does not abort the sequence. It completes and the byte is delivered, flagged via `spurious`.
- `int_enable` is ignored outside IDLE.
- `handler_done` is ignored outside WAIT_DONE. This includes the handshake cycle itself.
- `vector` holds its last value until the next capture. `vector_valid` stays high until accepted, with no timeout.
- From IDLE, a still-high `int_sync` starts a new sequence on the next edge (this covers other pending IRs).

## Timing
- Reset values: `inta_n`=1, `vector`=8'h00, `vector_valid`=0, `ocw2_wr`=0, `ocw2_data`=8'h00, `spurious`=0, `busy`=0, state IDLE, synchronizer 0.
- Reset is asynchronous. Asserting it mid-pulse raises `inta_n` immediately.
- With `int_req` rising before edge 1, `int_sync` is high after edge 2, and `inta_n` falls after edge 3.
- With default parameters:
  - `inta_n` is low for edges 3–5, high for 5–6, low for 6–8.
  - Capture happens at edge 8, and `vector_valid` is high after edge 8.
- Handshake completes on the edge where `vector_valid && vector_ready`. `vector_valid` is low after that edge.
- `ocw2_wr` is high for exactly the one cycle after the edge that samples `handler_done`.
- Minimum IDLE dwell between sequences: 1 cycle.

## Structure
- `pic_pkg` holds:
  - the state enum `inta_state_t`;
  - `OCW2_NONSPEC_EOI = 8'h20`;
  - the default pulse/gap constants shared with the PIC bench.
- One sub-module: `sync2` (2-flop synchronizer, reset to 0 by `rst_n`).
- Everything else (FSM, counter, capture) lives in `inta_sequencer`.

## Test plan
- Defaults, `int_req`=1, `int_enable`=1, `data_in`=8'h43 during ACK2 → `inta_n` low for edges 3–5 and 6–8; `vector`=8'h43 and `vector_valid` after edge 8; `spurious`=0.
- `vector_ready` held low for 5 cycles, then pulsed; `handler_done` pulsed 3 cycles later → `vector_valid` held for all 5 cycles; exactly one `ocw2_wr` with `ocw2_data`=8'h20; `busy` falls after the EOI cycle.
- `AUTO_EOI`=1, same stimulus → no `ocw2_wr` ever; IDLE on the cycle after the handshake.
- `int_req` dropped during GAP, `data_in`=8'h47 → sequence completes, `vector`=8'h47, `spurious`=1.
- `int_enable`=0 with `int_req`=1 → `inta_n` stays 1; raise `int_enable` → sequence starts on the next edge.
- `rst_n` asserted mid-ACK2 → `inta_n`=1 and all outputs at reset values immediately; after release with `int_req` still high, a full new sequence runs.
